fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter H_WORDS, 320, frame buffer words per line; each word holds 2 pixels.
REQ-002 Parameter V_LINES, 480, lines per frame.
REQ-003 Parameter BG_COLOR, 4'h8, default clear colour index.
REQ-004 The design SHALL use one clock and a synchronous, active-high reset.
REQ-005 Clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 clear_start  in  1  one-cycle pulse requesting a full frame-buffer clear.
REQ-008 clear_color  in  4  colour index for a requested clear; it SHALL be sampled with clear_start.
REQ-009 req_r, req_b  in  1 each  level write requests from the red and blue bike.
REQ-010 x_r, y_r, x_b, y_b  in  10 each  pixel coordinates, held stable while the request is pending.
REQ-011 color_r, color_b  in  4 each  trail colour index.
REQ-012 gnt_r, gnt_b  out  1 each  one-cycle grant pulses.
REQ-013 drop  out  1  one-cycle pulse: the granted request was out of range and was not written.
REQ-014 busy  out  1  high while a clear is in progress.
REQ-015 clear_done  out  1  one-cycle pulse after the last clear write.
REQ-016 WE  out  1  frame buffer write enable.
REQ-017 write_address  out  19  frame buffer word address.
REQ-018 Data_In  out  16  frame buffer write word.

Function
REQ-019 The block SHALL have two states: CLEAR and ARB.
REQ-020 All outputs SHALL be registered.
REQ-021 CLEAR: on each cycle the block SHALL assert WE=1, drive write_address = clr_cnt and Data_In = {4'h0,c,4'h0,c}, then increment clr_cnt.
  - c is the latched clear colour.
  - The first clear write SHALL be to address 0 and the last to H_WORDS*V_LINES-1 (153599).
REQ-022 After the write to 153599, the block SHALL move to ARB on the next cycle.
  - In that cycle: clear_done=1, busy=0, WE=0.
REQ-023 No grants SHALL be issued in CLEAR; pending requests SHALL simply wait.
REQ-024 ARB: the block SHALL sample requests each cycle and make at most one grant per cycle.
  - If only one eligible request is present, it SHALL be granted.
  - If both are eligible, the requester not granted last SHALL win (round-robin).
  - After reset, red SHALL hold priority.
REQ-025 A requester whose gnt is high in the current cycle SHALL be ineligible in that cycle, so a held req is never granted twice for one write.
REQ-026 Grant latency: a request sampled at edge k SHALL produce, after edge k and for one cycle, all of the following together:
  - gnt high;
  - WE high;
  - write_address = (x>>1) + y*H_WORDS;
  - Data_In = {4'h0,color,4'h0,color}.
REQ-027 y*320 SHALL be computed as (y<<8)+(y<<6) at 19-bit width with no truncation.
REQ-028 If x>=640 or y>=480, the block SHALL still issue gnt, but with WE=0 and drop=1; write_address and Data_In SHALL hold their previous values.
REQ-029 When no grant occurs, WE=0 and write_address and Data_In SHALL hold their previous values.
REQ-030 clear_start in ARB SHALL cause entry to CLEAR on the next cycle with clr_cnt=0 and busy=1.
  - If a request is present in the same cycle, clear_start SHALL win and no grant SHALL be issued.
REQ-031 clear_start during CLEAR SHALL restart the clear from address 0 with the newly sampled clear_color.

Reset
REQ-032 While Reset=1, outputs SHALL be: WE=0, write_address=0, Data_In=0, gnt_r=gnt_b=0, drop=0, clear_done=0, busy=1.
REQ-033 Reset SHALL set the state to CLEAR, clr_cnt=0, clear colour=BG_COLOR and round-robin priority=red.
REQ-034 The first clear write (address 0) SHALL occur in the first cycle after Reset falls.
REQ-035 Reset asserted mid-clear or mid-grant SHALL abort the operation on the next edge; no partial-cycle outputs SHALL persist.

Verification
REQ-036 Reset release: WE=1 for 153600 consecutive cycles with addresses 0..153599 and Data_In=16'h0808; then clear_done=1 for one cycle and busy=0.
REQ-037 In ARB, req_r with x=5, y=2, color=3: next cycle gnt_r=1, WE=1, write_address=642, Data_In=16'h0303.
REQ-038 req_r and req_b held together in ARB: grants alternate r,b,r,b, one per cycle, with no requester granted in two consecutive cycles.
REQ-039 req_b with x=639, y=479, color=2 gives address 153599 and data 16'h0202; req_b with x=640 gives gnt_b=1, drop=1, WE=0.
REQ-040 clear_start (clear_color=4'h0) in the same cycle as req_r: no gnt_r; CLEAR restarts at address 0 with data 16'h0000; gnt_r follows the cycle after clear_done.
REQ-041 Reset pulsed at clr_cnt=1000: the next clear write is to address 0 with colour BG_COLOR.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: clears the whole buffer to one colour, then grants
// single-pixel writes from the red and blue bikes round-robin, one per cycle.
module fb_write_arbiter #(
  parameter int          H_WORDS  = 320,
  parameter int          V_LINES  = 480,
  parameter logic [3:0]  BG_COLOR = 4'h8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_start,
  input  logic [3:0]  clear_color,
  input  logic        req_r,
  input  logic        req_b,
  input  logic [9:0]  x_r,
  input  logic [9:0]  y_r,
  input  logic [9:0]  x_b,
  input  logic [9:0]  y_b,
  input  logic [3:0]  color_r,
  input  logic [3:0]  color_b,
  output logic        gnt_r,
  output logic        gnt_b,
  output logic        drop,
  output logic        busy,
  output logic        clear_done,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In
);

  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  localparam logic [18:0] CLR_WORDS = 19'(H_WORDS * V_LINES);
  localparam logic [10:0] X_LIM     = 11'(2 * H_WORDS);
  localparam logic [10:0] Y_LIM     = 11'(V_LINES);

  state_t      state_q, state_d;
  logic [18:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]  clr_color_q, clr_color_d;
  logic        prio_b_q, prio_b_d;
  logic        we_q, we_d, gnt_r_q, gnt_r_d, gnt_b_q, gnt_b_d;
  logic        drop_q, drop_d, busy_q, busy_d, done_q, done_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic        elig_r, elig_b, pick_r, pick_b;
  logic [9:0]  sel_x, sel_y;
  logic [3:0]  sel_color;
  logic [18:0] sel_yw, sel_base;

  // Line base address; the 320-word geometry uses the shift-add form.
  always_comb begin
    sel_yw = {9'd0, sel_y};
    if (H_WORDS == 320) sel_base = (sel_yw << 8) + (sel_yw << 6);
    else                sel_base = sel_yw * 19'(H_WORDS);
  end

  // A requester granted this cycle sits out the next sample so a held req writes once.
  always_comb begin
    elig_r    = req_r & ~gnt_r_q;
    elig_b    = req_b & ~gnt_b_q;
    pick_r    = elig_r & (~elig_b | ~prio_b_q);
    pick_b    = elig_b & ~pick_r;
    sel_x     = pick_r ? x_r : x_b;
    sel_y     = pick_r ? y_r : y_b;
    sel_color = pick_r ? color_r : color_b;
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    prio_b_d    = prio_b_q;
    we_d        = 1'b0;
    gnt_r_d     = 1'b0;
    gnt_b_d     = 1'b0;
    drop_d      = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    if (clear_start) begin
      state_d     = ST_CLEAR;
      clr_cnt_d   = '0;
      clr_color_d = clear_color;
      busy_d      = 1'b1;
    end else if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == CLR_WORDS) begin
        state_d = ST_ARB;
        done_d  = 1'b1;
      end else begin
        busy_d    = 1'b1;
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        data_d    = {4'h0, clr_color_q, 4'h0, clr_color_q};
        clr_cnt_d = clr_cnt_q + 19'd1;
      end
    end else if (pick_r || pick_b) begin
      gnt_r_d  = pick_r;
      gnt_b_d  = pick_b;
      prio_b_d = pick_r;
      if ({1'b0, sel_x} < X_LIM && {1'b0, sel_y} < Y_LIM) begin
        we_d   = 1'b1;
        addr_d = {10'd0, sel_x[9:1]} + sel_base;
        data_d = {4'h0, sel_color, 4'h0, sel_color};
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      clr_color_q <= BG_COLOR;
      prio_b_q    <= 1'b0;
      we_q        <= 1'b0;
      gnt_r_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      prio_b_q    <= prio_b_d;
      we_q        <= we_d;
      gnt_r_q     <= gnt_r_d;
      gnt_b_q     <= gnt_b_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign gnt_r         = gnt_r_q;
  assign gnt_b         = gnt_b_q;
  assign drop          = drop_q;
  assign busy          = busy_q;
  assign clear_done    = done_q;
  assign WE            = we_q;
  assign write_address = addr_q;
  assign Data_In       = data_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: full-width lines with a short frame so every clear
// runs to completion; random arbitration is checked against a rule-level model.
module tb_fb_write_arbiter;

  localparam int HW = 320;
  localparam int VL = 8;
  localparam int NW = HW * VL;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        clear_start = 1'b0;
  logic [3:0]  clear_color = 4'h0;
  logic        req_r = 1'b0, req_b = 1'b0;
  logic [9:0]  x_r = '0, y_r = '0, x_b = '0, y_b = '0;
  logic [3:0]  color_r = '0, color_b = '0;
  logic        gnt_r, gnt_b, drop, busy, clear_done, WE;
  logic [18:0] write_address;
  logic [15:0] Data_In;

  fb_write_arbiter #(.H_WORDS(HW), .V_LINES(VL), .BG_COLOR(4'h8)) dut (
    .Clk(Clk), .Reset(Reset), .clear_start(clear_start), .clear_color(clear_color),
    .req_r(req_r), .req_b(req_b), .x_r(x_r), .y_r(y_r), .x_b(x_b), .y_b(y_b),
    .color_r(color_r), .color_b(color_b), .gnt_r(gnt_r), .gnt_b(gnt_b),
    .drop(drop), .busy(busy), .clear_done(clear_done), .WE(WE),
    .write_address(write_address), .Data_In(Data_In)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: previous-cycle grants, who was granted last, held address/data.
  logic        m_gr = 1'b0, m_gb = 1'b0;
  logic        m_last_blue = 1'b1;
  logic [18:0] m_addr = '0;
  logic [15:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(input logic [3:0] c);
    return {4'h0, c, 4'h0, c};
  endfunction

  task automatic reset_check();
    chk("rst_we", WE, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", Data_In, 0);
    chk("rst_gnt_r", gnt_r, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_drop", drop, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_busy", busy, 1);
    m_gr = 0; m_gb = 0; m_last_blue = 1; m_addr = '0; m_data = '0;
  endtask

  task automatic clear_writes(input logic [3:0] c, input int count);
    for (int i = 0; i < count; i++) begin
      step();
      chk("clr_we", WE, 1);
      chk("clr_addr", write_address, i);
      chk("clr_data", Data_In, word_of(c));
      chk("clr_busy", busy, 1);
      chk("clr_gnt", {gnt_r, gnt_b}, 0);
    end
    if (count > 0) begin
      m_addr = 19'(count - 1);
      m_data = word_of(c);
    end
    m_gr = 0; m_gb = 0;
  endtask

  task automatic done_step();
    step();
    chk("done_pulse", clear_done, 1);
    chk("done_busy", busy, 0);
    chk("done_we", WE, 0);
    chk("done_gnt", {gnt_r, gnt_b}, 0);
    chk("done_addr", write_address, m_addr);
  endtask

  task automatic start_clear(input logic [3:0] c);
    clear_start = 1; clear_color = c;
    step();
    clear_start = 0;
    chk("cs_we", WE, 0);
    chk("cs_busy", busy, 1);
    chk("cs_gnt", {gnt_r, gnt_b}, 0);
    chk("cs_addr", write_address, m_addr);
    m_gr = 0; m_gb = 0;
  endtask

  task automatic arb_cycle();
    logic er, eb, pr, pb, in_rng, e_we;
    int   sx, sy;
    logic [3:0] sc;
    er = req_r && !m_gr;
    eb = req_b && !m_gb;
    pr = er && (!eb || m_last_blue);
    pb = eb && !pr;
    sx = pr ? int'(x_r) : int'(x_b);
    sy = pr ? int'(y_r) : int'(y_b);
    sc = pr ? color_r : color_b;
    in_rng = (sx < 2 * HW) && (sy < VL);
    e_we = (pr || pb) && in_rng;
    if (e_we) begin
      m_addr = 19'(sx / 2 + sy * HW);
      m_data = word_of(sc);
    end
    step();
    chk("arb_gnt_r", gnt_r, pr);
    chk("arb_gnt_b", gnt_b, pb);
    chk("arb_we", WE, e_we);
    chk("arb_drop", drop, (pr || pb) && !in_rng);
    chk("arb_addr", write_address, m_addr);
    chk("arb_data", Data_In, m_data);
    chk("arb_busy", busy, 0);
    m_gr = pr; m_gb = pb;
    if (pr) m_last_blue = 0;
    if (pb) m_last_blue = 1;
  endtask

  initial begin
    // Reset state
    Reset = 1;
    step(); step();
    reset_check();

    // Reset release: full clear in BG colour while a red request waits
    req_r = 1; x_r = 10'd5; y_r = 10'd2; color_r = 4'd3;
    Reset = 0;
    clear_writes(4'h8, NW);
    done_step();
    arb_cycle();
    chk("single_gnt_r", gnt_r, 1);
    chk("single_addr", write_address, 642);
    chk("single_data", Data_In, 16'h0303);
    req_r = 0;
    arb_cycle();

    // Both held: strict alternation, red was granted last so blue leads
    req_r = 1; req_b = 1; x_b = 10'd10; y_b = 10'd3; color_b = 4'd9;
    arb_cycle();
    chk("alt_first_b", gnt_b, 1);
    repeat (6) arb_cycle();
    req_r = 0; req_b = 0;
    arb_cycle();

    // Range boundaries
    req_b = 1; x_b = 10'd639; y_b = 10'(VL - 1); color_b = 4'd2;
    arb_cycle();
    chk("edge_addr", write_address, NW - 1);
    chk("edge_data", Data_In, 16'h0202);
    req_b = 0;
    arb_cycle();
    req_b = 1; x_b = 10'd640; y_b = 10'd0; color_b = 4'd7;
    arb_cycle();
    chk("oob_x_drop", drop, 1);
    chk("oob_x_gnt", gnt_b, 1);
    chk("oob_x_we", WE, 0);
    req_b = 0;
    arb_cycle();
    req_r = 1; x_r = 10'd4; y_r = 10'(VL); color_r = 4'd1;
    arb_cycle();
    chk("oob_y_drop", drop, 1);
    req_r = 0;
    arb_cycle();

    // Random arbitration traffic
    repeat (400) begin
      req_r = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      x_r = 10'($urandom_range(0, 700));
      y_r = 10'($urandom_range(0, VL + 2));
      x_b = 10'($urandom_range(0, 700));
      y_b = 10'($urandom_range(0, VL + 2));
      color_r = 4'($urandom_range(0, 15));
      color_b = 4'($urandom_range(0, 15));
      arb_cycle();
    end
    req_r = 0; req_b = 0;
    arb_cycle();

    // clear_start wins over a simultaneous request
    req_r = 1; x_r = 10'd5; y_r = 10'd2; color_r = 4'd3;
    start_clear(4'h0);
    clear_writes(4'h0, NW);
    done_step();
    arb_cycle();
    chk("post_clear_gnt_r", gnt_r, 1);
    req_r = 0;
    arb_cycle();

    // Restart mid-clear, then reset at clr_cnt=1000
    start_clear(4'h5);
    clear_writes(4'h5, 100);
    start_clear(4'h6);
    clear_writes(4'h6, 1000);
    Reset = 1;
    step();
    reset_check();
    Reset = 0;
    clear_writes(4'h8, NW);
    done_step();

    // Priority back to red after reset
    req_r = 1; req_b = 1;
    arb_cycle();
    chk("rst_prio_red", gnt_r, 1);
    repeat (3) arb_cycle();
    req_r = 0; req_b = 0;
    arb_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
